// File: rtl/rr_stream_mux.sv
// rr_stream_mux: N-to-1 valid/ready stream merge with round-robin grant.
// Define MUX_PKT_LOCK_EN to hold the grant on one channel until in_last.
module rr_stream_mux #(
    parameter int N = 4,
    parameter int W = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [N*W-1:0]         in_data,
    input  logic [N-1:0]           in_valid,
    input  logic [N-1:0]           in_last,
    output logic [N-1:0]           in_ready,
    output logic [W-1:0]           out_data,
    output logic                   out_valid,
    output logic                   out_last,
    output logic [$clog2(N)-1:0]   out_sel,
    input  logic                   out_ready
);
    localparam int SW = $clog2(N);

    logic [SW-1:0] ptr;
    logic [SW-1:0] grant;
    logic [SW-1:0] cand;
    logic [SW-1:0] next_ptr;
    logic [N-1:0]  elig;
    logic          any_valid;
    logic          load;
    logic          xfer;

    function automatic logic [SW-1:0] wrap_add(input logic [SW-1:0] a, input int k);
        int s;
        s = int'(a) + k;
        if (s >= N) s = s - N;
        return SW'(s);
    endfunction

`ifdef MUX_PKT_LOCK_EN
    logic          lock;
    logic [SW-1:0] locked_ch;

    always_comb begin
        elig = in_valid;
        if (lock) elig = in_valid & (N'(1) << locked_ch);
    end
`else
    assign elig = in_valid;
`endif

    // Scan from the far end so the channel nearest ptr wins.
    always_comb begin
        grant     = '0;
        cand      = '0;
        any_valid = 1'b0;
        for (int k = N - 1; k >= 0; k--) begin
            cand = wrap_add(ptr, k);
            if (elig[cand]) begin
                grant     = cand;
                any_valid = 1'b1;
            end
        end
    end

    assign load     = ~out_valid | out_ready;
    assign xfer     = any_valid & load;
    assign next_ptr = (grant == SW'(N - 1)) ? '0 : grant + SW'(1);

    always_comb begin
        in_ready = '0;
        if (xfer) in_ready[grant] = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_last  <= 1'b0;
            out_sel   <= '0;
        end else if (xfer) begin
            out_valid <= 1'b1;
            out_data  <= in_data[grant*W +: W];
            out_last  <= in_last[grant];
            out_sel   <= grant;
        end else if (load) begin
            out_valid <= 1'b0;
        end
    end

`ifdef MUX_PKT_LOCK_EN
    // A non-final beat pins the grant; ptr only moves past a finished packet.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr       <= '0;
            lock      <= 1'b0;
            locked_ch <= '0;
        end else if (xfer) begin
            if (!in_last[grant]) begin
                lock      <= 1'b1;
                locked_ch <= grant;
            end else begin
                lock <= 1'b0;
                ptr  <= next_ptr;
            end
        end
    end
`else
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= '0;
        end else if (xfer) begin
            ptr <= next_ptr;
        end
    end
`endif

endmodule

// File: tb/tb_rr_stream_mux.sv
// tb_rr_stream_mux: directed and random checks of rr_stream_mux against
// a queue-based reference model (honours MUX_PKT_LOCK_EN when defined).
module tb_rr_stream_mux;
    localparam int N  = 4;
    localparam int W  = 8;
    localparam int D  = 1024;
    localparam int SW = $clog2(N);

    logic           clk;
    logic           rst_n;
    logic [N*W-1:0] in_data;
    logic [N-1:0]   in_valid;
    logic [N-1:0]   in_last;
    logic [N-1:0]   in_ready;
    logic [W-1:0]   out_data;
    logic           out_valid;
    logic           out_last;
    logic [SW-1:0]  out_sel;
    logic           out_ready;

    rr_stream_mux #(.N(N), .W(W)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_data(in_data), .in_valid(in_valid), .in_last(in_last),
        .in_ready(in_ready),
        .out_data(out_data), .out_valid(out_valid), .out_last(out_last),
        .out_sel(out_sel), .out_ready(out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;

    // Per-channel source queues: bit W is last, bits W-1:0 are data.
    logic [W:0] mem [N][D];
    int head [N];
    int tail [N];

    int         m_ptr;
    bit         m_valid;
    logic [W-1:0] m_data;
    bit         m_last;
    int         m_sel;
    bit         m_lock;
    int         m_lch;
    int         last_g;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic push(input int c, input logic [W-1:0] d, input bit l);
        mem[c][tail[c]] = {l, d};
        tail[c]++;
    endtask

    task automatic drive();
        for (int c = 0; c < N; c++) begin
            if (head[c] < tail[c]) begin
                in_valid[c]       = 1'b1;
                in_data[c*W +: W] = mem[c][head[c]][W-1:0];
                in_last[c]        = mem[c][head[c]][W];
            end else begin
                in_valid[c]       = 1'b0;
                in_data[c*W +: W] = '0;
                in_last[c]        = 1'b0;
            end
        end
    endtask

    function automatic int pick();
        for (int k = 0; k < N; k++) begin
            int c;
            c = (m_ptr + k) % N;
            if (in_valid[c] && (!m_lock || c == m_lch)) return c;
        end
        return -1;
    endfunction

    task automatic apply_reset();
        rst_n = 1'b0;
        out_ready = 1'b0;
        for (int c = 0; c < N; c++) begin
            head[c] = 0;
            tail[c] = 0;
        end
        drive();
        m_ptr = 0; m_valid = 0; m_data = '0; m_last = 0;
        m_sel = 0; m_lock = 0; m_lch = 0;
        @(posedge clk);
        #3 rst_n = 1'b1;
    endtask

    task automatic tick();
        int g;
        bit load;
        bit l;
        logic [N-1:0] exp_rdy;
        drive();
        #1;
        load = !m_valid || out_ready;
        g = pick();
        exp_rdy = '0;
        if (load && g >= 0) exp_rdy[g] = 1'b1;
        chk("in_ready", 32'(in_ready), 32'(exp_rdy));
        @(posedge clk);
        #1;
        last_g = -1;
        if (load && g >= 0) begin
            l = in_last[g];
            m_valid = 1;
            m_data  = in_data[g*W +: W];
            m_last  = l;
            m_sel   = g;
            last_g  = g;
            head[g]++;
`ifdef MUX_PKT_LOCK_EN
            if (!l) begin
                m_lock = 1;
                m_lch  = g;
            end else begin
                m_lock = 0;
                m_ptr  = (g + 1) % N;
            end
`else
            m_ptr = (g + 1) % N;
`endif
        end else if (load) begin
            m_valid = 0;
        end
        chk("out_valid", 32'(out_valid), 32'(m_valid));
        chk("out_data", 32'(out_data), 32'(m_data));
        chk("out_sel", 32'(out_sel), m_sel);
        chk("out_last", 32'(out_last), 32'(m_last));
    endtask

    initial begin
        logic [W-1:0] t2 [3];
        int exp6 [5];
        int n6;
        t2[0] = 8'h11; t2[1] = 8'h22; t2[2] = 8'h33;
        in_data = '0; in_valid = '0; in_last = '0;

        // Asynchronous reset with a live beat in the output register.
        apply_reset();
        push(0, 8'h5A, 1'b1);
        push(0, 8'h6B, 1'b1);
        tick();
        tick();
        chk("pre_rst_valid", 32'(out_valid), 32'd1);
        #3 rst_n = 1'b0;
        #1;
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_data", 32'(out_data), 32'd0);
        chk("rst_sel", 32'(out_sel), 32'd0);
        chk("rst_last", 32'(out_last), 32'd0);
        apply_reset();
        tick();
        chk("rst_idle", 32'(out_valid), 32'd0);

        // Single channel back-to-back.
        apply_reset();
        out_ready = 1'b1;
        push(2, 8'h11, 1'b0);
        push(2, 8'h22, 1'b0);
        push(2, 8'h33, 1'b1);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("single_data", 32'(out_data), 32'(t2[i]));
            chk("single_sel", 32'(out_sel), 32'd2);
        end
        tick();
        chk("single_drain", 32'(out_valid), 32'd0);

        // Round-robin order from reset with all channels valid.
        apply_reset();
        out_ready = 1'b1;
        for (int c = 0; c < N; c++) begin
            push(c, W'(8'h10 + c), 1'b1);
            push(c, W'(8'h20 + c), 1'b1);
        end
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("rr_sel", 32'(out_sel), 32'(i % N));
        end

        // Wrap-around: ptr parked at 3, channels 1 and 3 valid.
        apply_reset();
        out_ready = 1'b1;
        push(2, 8'h01, 1'b1);
        tick();
        push(1, 8'hB1, 1'b1);
        push(1, 8'hB2, 1'b1);
        push(3, 8'hD1, 1'b1);
        push(3, 8'hD2, 1'b1);
        tick();
        chk("wrap_sel0", 32'(out_sel), 32'd3);
        tick();
        chk("wrap_sel1", 32'(out_sel), 32'd1);
        tick();
        chk("wrap_sel2", 32'(out_sel), 32'd3);

        // Backpressure holds the beat, then reload with no bubble.
        apply_reset();
        out_ready = 1'b1;
        push(0, 8'hA5, 1'b1);
        push(1, 8'h3C, 1'b1);
        push(2, 8'h77, 1'b1);
        tick();
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("stall_data", 32'(out_data), 32'hA5);
            chk("stall_valid", 32'(out_valid), 32'd1);
        end
        out_ready = 1'b1;
        tick();
        chk("resume_valid", 32'(out_valid), 32'd1);
        chk("resume_data", 32'(out_data), 32'h3C);
        chk("resume_sel", 32'(out_sel), 32'd1);

        // Three-beat packet on ch0 against a steady ch1.
        apply_reset();
        out_ready = 1'b1;
        push(0, 8'hC0, 1'b0);
        push(0, 8'hC1, 1'b0);
        push(0, 8'hC2, 1'b1);
        for (int i = 0; i < 3; i++) push(1, W'(8'hE0 + i), 1'b1);
`ifdef MUX_PKT_LOCK_EN
        exp6[0] = 0; exp6[1] = 0; exp6[2] = 0; exp6[3] = 1; exp6[4] = 0;
        n6 = 4;
`else
        exp6[0] = 0; exp6[1] = 1; exp6[2] = 0; exp6[3] = 1; exp6[4] = 0;
        n6 = 5;
`endif
        for (int i = 0; i < n6; i++) begin
            tick();
            chk("pkt_sel", 32'(out_sel), exp6[i]);
        end

        // Random traffic and backpressure against the model.
        apply_reset();
        for (int i = 0; i < 400; i++) begin
            for (int c = 0; c < N; c++) begin
                if ($urandom_range(0, 2) == 0 && tail[c] - head[c] < 4 && tail[c] < D)
                    push(c, W'($urandom), 1'($urandom_range(0, 1)));
            end
            out_ready = ($urandom_range(0, 3) != 0);
            tick();
        end
        out_ready = 1'b1;
        repeat (20) tick();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
